// File: rtl/draw_rect_ctl_if.sv
// VGA timing bus. The rectangle controller only looks at the pixel counters.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;

  modport in  (input  hcount, vcount);
  modport out (output hcount, vcount);
endinterface

// File: rtl/draw_rect_ctl.sv
// Mouse-driven rectangle controller: per-frame drag, grow and shrink of a box
// whose geometry is clamped to the visible screen and the size bounds.
module draw_rect_ctl #(
  parameter int STEP     = 8,
  parameter int MIN_SIZE = 8,
  parameter int MAX_SIZE = 256,
  parameter int X_INIT   = 150,
  parameter int Y_INIT   = 100,
  parameter int H_RES    = 800,
  parameter int V_RES    = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic        mouse_middle,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  vga_if.in           vga_in,
  output logic [11:0] xpos_rect,
  output logic [11:0] ypos_rect,
  output logic [11:0] width_rect,
  output logic [11:0] height_rect,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GROW   = 2'd1,
    SHRINK = 2'd2,
    DRAG   = 2'd3
  } state_e;

  // 13-bit working width so sums and differences of 12-bit values never wrap
  localparam logic [12:0] STEP_W  = 13'(STEP);
  localparam logic [12:0] MIN_W   = 13'(MIN_SIZE);
  localparam logic [12:0] MAX_W   = 13'(MAX_SIZE);
  localparam logic [12:0] H_RES_W = 13'(H_RES);
  localparam logic [12:0] V_RES_W = 13'(V_RES);

  function automatic logic [12:0] room_left(input logic [12:0] res, input logic [11:0] used);
    return (res > {1'b0, used}) ? res - {1'b0, used} : 13'd0;
  endfunction

  function automatic logic [11:0] grow_sz(input logic [11:0] cur, input logic [11:0] pos,
                                          input logic [12:0] res);
    logic [12:0] sum;
    logic [12:0] lim;
    logic [12:0] room;
    sum  = {1'b0, cur} + STEP_W;
    room = room_left(res, pos);
    lim  = (room < MAX_W) ? room : MAX_W;
    return (sum > lim) ? lim[11:0] : sum[11:0];
  endfunction

  function automatic logic [11:0] shrink_sz(input logic [11:0] cur);
    logic [12:0] diff;
    diff = {1'b0, cur} - STEP_W;
    return ({1'b0, cur} >= MIN_W + STEP_W) ? diff[11:0] : MIN_W[11:0];
  endfunction

  function automatic logic [11:0] drag_pos(input logic [11:0] m, input logic [11:0] sz,
                                           input logic [12:0] res);
    logic [12:0] room;
    room = room_left(res, sz);
    return ({1'b0, m} > room) ? room[11:0] : m;
  endfunction

  state_e      state_q, state_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [11:0] width_q, width_d;
  logic [11:0] height_q, height_d;
  // button vectors are ordered {left, right, middle}
  logic [2:0]  btn_prev_q, btn_prev_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  rise;
  logic        frame_tick;
  logic        ev_left, ev_right, ev_mid;

  always_comb begin
    frame_tick = (vga_in.hcount == '0) && (vga_in.vcount == '0);
    btn_prev_d = {mouse_left, mouse_right, mouse_middle};
    rise       = btn_prev_d & ~btn_prev_q;

    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    width_d  = width_q;
    height_d = height_q;
    pend_d   = pend_q | rise;
    ev_left  = 1'b0;
    ev_right = 1'b0;
    ev_mid   = 1'b0;

    if (frame_tick) begin
      // old flags are consumed here; an edge arriving on this very cycle waits a frame
      pend_d   = rise;
      ev_left  = pend_q[2];
      ev_right = pend_q[1] & ~pend_q[2];
      ev_mid   = pend_q[0] & ~pend_q[2] & ~pend_q[1];

      unique case (state_q)
        IDLE:   state_d = ev_left ? DRAG : ev_right ? GROW   : ev_mid ? SHRINK : IDLE;
        GROW:   state_d = ev_left ? DRAG : ev_right ? IDLE   : ev_mid ? SHRINK : GROW;
        SHRINK: state_d = ev_left ? DRAG : ev_right ? GROW   : ev_mid ? IDLE   : SHRINK;
        DRAG:   state_d = ev_left ? IDLE : DRAG;
        default: state_d = IDLE;
      endcase

      // the mode entered on this tick takes its step on the same tick
      unique case (state_d)
        GROW: begin
          width_d  = grow_sz(width_q,  xpos_q, H_RES_W);
          height_d = grow_sz(height_q, ypos_q, V_RES_W);
        end
        SHRINK: begin
          width_d  = shrink_sz(width_q);
          height_d = shrink_sz(height_q);
        end
        DRAG: begin
          xpos_d = drag_pos(mouse_xpos, width_q,  H_RES_W);
          ypos_d = drag_pos(mouse_ypos, height_q, V_RES_W);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      xpos_q     <= 12'(X_INIT);
      ypos_q     <= 12'(Y_INIT);
      width_q    <= 12'(MIN_SIZE);
      height_q   <= 12'(MIN_SIZE);
      btn_prev_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      width_q    <= width_d;
      height_q   <= height_d;
      btn_prev_q <= btn_prev_d;
      pend_q     <= pend_d;
    end
  end

  assign xpos_rect   = xpos_q;
  assign ypos_rect   = ypos_q;
  assign width_rect  = width_q;
  assign height_rect = height_q;
  assign mode        = state_q;

endmodule
